mix_columns_seq: RTL and testbench
==================================

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, upstream asserts when in_state holds a block.
REQ-004 SHALL have port in_ready, output, 1, block can accept a new state.
REQ-005 SHALL have port in_state, input, 128, AES state; column c = bits [127-32c -: 32]; row 0 byte = MSB byte of each column.
REQ-006 SHALL have port out_valid, output, 1, out_state holds the MixColumns result.
REQ-007 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-008 SHALL have port out_state, output, 128, MixColumns(in_state), same byte layout as in_state.
REQ-009 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-010 SHALL compute the forward AES MixColumns, matrix rows {02 03 01 01} rotated, over GF(2^8) with reduction polynomial 0x11B.
REQ-011 SHALL implement multiply-by-2 as a shift plus conditional XOR of 0x1B, and multiply-by-3 as x2 XOR x1; no 256-entry tables.
REQ-012 SHALL use the three-state FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-013 In IDLE, in_ready SHALL be 1; a handshake (in_valid & in_ready) at edge k SHALL capture in_state, clear the column counter and move to BUSY.
REQ-014 In BUSY, a 2-bit column counter SHALL process column 0, 1, 2, 3 on consecutive edges k+1..k+4 and write each result column into the output register.
REQ-015 At counter value 3, the FSM SHALL go to DONE; out_valid SHALL be 1 from edge k+4, giving a fixed 4-cycle latency.
REQ-016 In DONE, out_valid and out_state SHALL hold stable until out_ready is 1; then the FSM SHALL return to IDLE with out_valid 0.
REQ-017 in_ready SHALL be 0 in BUSY and DONE; in_valid in those states SHALL be ignored and SHALL NOT corrupt the captured block.
REQ-018 When out_ready is 1 and the FSM enters DONE, the FSM SHALL still spend one cycle in DONE, so the minimum throughput is one block per 6 cycles.
REQ-019 out_ready asserted outside DONE SHALL have no effect.
REQ-020 out_state SHALL retain the last result after the DONE->IDLE transition until the next block overwrites column 0.
REQ-021 in_state SHALL be read only at the capture edge; later changes to in_state SHALL NOT affect the result.

Reset
REQ-022 Assertion of rst_n low SHALL asynchronously force state IDLE, counter 0, captured register 0, out_state 0, out_valid 0, busy 0.
REQ-023 Reset during BUSY or DONE SHALL abort the block without emitting it; in_ready SHALL be 1 on the first edge after rst_n deasserts.

Structure
REQ-024 A shared AES package SHALL hold the reduction constant 8'h1B, the 128-bit state width, and the FSM state enumeration.
REQ-025 A combinational sub-module mix_single_column (32-bit in, 32-bit out) SHALL be instantiated once and time-multiplexed across the four columns.

Verification
REQ-026 Column db 13 53 45 in all four columns -> out_state = {8e 4d a1 bc} x4; out_valid rises exactly 4 cycles after capture.
REQ-027 in_state = {f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6, d4 d4 d4 d5} -> out_state = {9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6, d5 d5 d7 d6}.
REQ-028 Hold out_ready 0 for 10 cycles after out_valid -> out_state stable, in_ready 0, extra in_valid pulses ignored; out_ready 1 -> IDLE on the next edge.
REQ-029 Pull rst_n low at cycle 2 of BUSY -> out_valid 0 and out_state 0 immediately; a new block 2d 26 31 4c (x4) then yields {4d 7e bd f8} x4.
REQ-030 Stream back-to-back with in_valid and out_ready held at 1 -> one result every 6 cycles, with no dropped or duplicated block.
REQ-031 Randomized check of 1000 blocks against a reference model, with random in_valid/out_ready stalls -> all results match.

Source files
------------

// File: rtl/mix_columns_seq_pkg.sv
// mix_columns_seq_pkg: shared AES constants, FSM states and GF(2^8) doubling
package mix_columns_seq_pkg;
    localparam int STATE_W = 128;
    localparam logic [7:0] GF_POLY = 8'h1B;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/mix_single_column.sv
// mix_single_column: combinational forward MixColumns of one 32-bit column
module mix_single_column
    import mix_columns_seq_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = col;
    assign mixed = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: AES MixColumns, one column per cycle through a shared column mixer
module mix_columns_seq
    import mix_columns_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);
    state_t state, state_nxt;
    logic [1:0] cnt;
    logic [STATE_W-1:0] cap;
    logic [31:0] col_out;
    mix_single_column u_col (.col(cap[{~cnt, 5'd0} +: 32]), .mixed(col_out));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state == IDLE ? (in_valid ? BUSY : IDLE) :
                    state == BUSY ? (cnt == 2'd3 ? DONE : BUSY) :
                    (out_ready ? IDLE : DONE);
    end
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt       <= 2'd0;
            cap       <= '0;
            out_state <= '0;
        end else if (state == IDLE && in_valid) begin
            cap <= in_state;
            cnt <= 2'd0;
        end else if (state == BUSY) begin
            out_state[{~cnt, 5'd0} +: 32] <= col_out;
            cnt <= cnt + 2'd1;
        end
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed and randomized checks of mix_columns_seq
module tb_mix_columns_seq;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;
    int n_vec = 0;
    int n_err = 0;
    mix_columns_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
        end
        return p;
    endfunction
    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [7:0] cf [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [127:0] r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(s[127 - 32*c - 8*j -: 8], cf[(j - row + 4) % 4]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        return r;
    endfunction
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] exp);
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        in_state = d;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        in_state = ~d;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1 check({tag, "_ov"}, out_valid, i == 4);
        end
        check(tag, out_state, exp);
    endtask
    task automatic stream(input string tag, input int nblk, input bit stall);
        logic [127:0] q [$];
        int got = 0, pushed = 0, last = -1, cyc = 0;
        bit hs;
        in_state  = rand128();
        in_valid  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        while (got < nblk && cyc < 20 * nblk + 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) check({tag, "_dup"}, 1, 0);
                else check(tag, out_state, q.pop_front());
                if (!stall && last >= 0) check({tag, "_gap"}, 128'(cyc - last), 6);
                last = cyc;
                got++;
            end
            hs = in_valid && in_ready;
            if (hs) begin
                q.push_back(mix_ref(in_state));
                pushed++;
            end
            @(posedge clk);
            #1;
            if (hs) in_state = rand128();
            in_valid  = (pushed < nblk) && (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check({tag, "_count"}, 128'(got), 128'(nblk));
        check({tag, "_left"}, 128'(q.size()), 0);
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask
    initial begin
        logic [127:0] exp27;
        rst_n = 0;
        in_valid = 0;
        out_ready = 0;
        in_state = '0;
        #12;
        check("rst_ov", out_valid, 0);
        check("rst_rdy", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out", out_state, '0);
        @(negedge clk) rst_n = 1;
        run_block("db13", {4{32'hdb135345}}, {4{32'h8e4da1bc}});
        out_ready = 1;
        @(posedge clk);
        #1 check("db13_release", out_valid, 0);
        out_ready = 0;
        exp27 = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
        run_block("mix4", 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, exp27);
        check("mix4_busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1;
            in_state = rand128();
            @(posedge clk);
            #1 check("hold_out", out_state, exp27);
            check("hold_ov", out_valid, 1);
            check("hold_rdy", in_ready, 0);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1 check("hold_exit_ov", out_valid, 0);
        check("hold_exit_rdy", in_ready, 1);
        check("retain_out", out_state, exp27);
        out_ready = 0;
        @(negedge clk);
        in_state = 128'h0102030405060708090a0b0c0d0e0f10;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 0;
        #1 check("abort_ov", out_valid, 0);
        check("abort_out", out_state, '0);
        check("abort_busy", busy, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1 check("abort_rdy", in_ready, 1);
        run_block("post_rst", {4{32'h2d26314c}}, {4{32'h4d7ebdf8}});
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        stream("b2b", 12, 1'b0);
        stream("rand", 1000, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
